// File: rtl/cpu_trace_buffer.sv
// Event-trace capture for the pipelined core: circular, stop-when-full and PC-trigger modes, drained over valid/ready.
// Optional build macro TRACE_TIMESTAMP_EN prepends a 32-bit cycle timestamp to each record and adds ts_now.
module cpu_trace_buffer #(
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16,
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W     = 32,
`else
    localparam int TS_W     = 0,
`endif
    localparam int REC_W    = TS_W + 2 + REG_W + PC_W + DATA_W,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic [PC_W-1:0]   pc_ex,
    input  logic              regwrite_ex,
    input  logic [REG_W-1:0]  regsel_ex,
    input  logic [DATA_W-1:0] writedata,
    input  logic              gpio_we_wb,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [REC_W-1:0]  rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              triggered,
    output logic              overflow
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]       ts_now
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, post_cnt_reg;
    logic [CNT_W-1:0] count_reg;
    logic [1:0]       mode_reg;
    logic             triggered_reg, overflow_reg;
    logic [REC_W-1:0] mem [DEPTH];

    logic             event_in, capture, arm_accept, is_full;
    logic             trig_hit, fill_last, rd_valid_int, pop;
    logic [REC_W-1:0] record;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_reg <= '0;
        else     ts_reg <= ts_reg + 32'd1;
    end

    assign ts_now = ts_reg;
    assign record = {ts_reg, gpio_we_wb, regwrite_ex, regsel_ex, pc_ex, writedata};
`else
    assign record = {gpio_we_wb, regwrite_ex, regsel_ex, pc_ex, writedata};
`endif

    assign event_in     = regwrite_ex | gpio_we_wb;
    assign capture      = event_in && (state_reg == S_ARMED || state_reg == S_POST);
    assign arm_accept   = arm && (state_reg == S_IDLE || state_reg == S_DONE);
    assign is_full      = (count_reg == CNT_W'(DEPTH));
    assign trig_hit     = capture && state_reg == S_ARMED && mode_reg == 2'd2 && pc_ex == trig_pc;
    assign fill_last    = capture && state_reg == S_ARMED && mode_reg == 2'd1
                          && count_reg == CNT_W'(DEPTH - 1);
    assign rd_valid_int = (state_reg == S_DONE) && (count_reg != '0);
    // A same-cycle arm discards the buffer, so it suppresses the pop.
    assign pop          = rd_valid_int && rd_ready && !arm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (arm) state_next = S_ARMED;
            S_ARMED: begin
                if (stop || fill_last) state_next = S_DONE;
                else if (trig_hit)     state_next = (POST_TRIG == 0) ? S_DONE : S_POST;
            end
            S_POST: begin
                if (stop || (capture && post_cnt_reg == PTR_W'(1))) state_next = S_DONE;
            end
            S_DONE: begin
                if (arm) state_next = S_ARMED;
                else if (count_reg == '0 || (pop && count_reg == CNT_W'(1))) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg == S_ARMED) || (state_reg == S_POST);
        rd_valid = rd_valid_int;
        rd_data  = rd_valid_int ? mem[rd_ptr_reg] : '0;
    end

    assign count     = count_reg;
    assign triggered = triggered_reg;
    assign overflow  = overflow_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            post_cnt_reg  <= '0;
            mode_reg      <= 2'd0;
            triggered_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (arm_accept) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            triggered_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            mode_reg      <= (mode == 2'd3) ? 2'd0 : mode;
        end else begin
            if (capture) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                // Full buffer: the oldest record is dropped by moving the read side along.
                if (is_full) begin
                    rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
                    overflow_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
            if (trig_hit) begin
                triggered_reg <= 1'b1;
                post_cnt_reg  <= PTR_W'(POST_TRIG);
            end else if (capture && state_reg == S_POST) begin
                post_cnt_reg <= post_cnt_reg - PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                count_reg  <= count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr_reg] <= record;
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Randomised and directed bench for cpu_trace_buffer against a queue-based reference model.
module tb_cpu_trace_buffer;
    localparam int DEPTH     = 64;
    localparam int POST_TRIG = 16;
    localparam int BASE_W    = 71;
`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_W = BASE_W + 32;
`else
    localparam int REC_W = BASE_W;
`endif

    logic clk = 0, rst = 0, arm = 0, stop = 0, regwrite_ex = 0, gpio_we_wb = 0, rd_ready = 0;
    logic [1:0]  mode = 0;
    logic [31:0] trig_pc = 0, pc_ex = 0, writedata = 0;
    logic [4:0]  regsel_ex = 0;
    logic        rd_valid, busy, triggered, overflow;
    logic [REC_W-1:0] rd_data;
    logic [6:0]  count;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_now;
`endif

    cpu_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
`ifdef TRACE_TIMESTAMP_EN
        .ts_now(ts_now),
`endif
        .clk(clk), .rst(rst), .arm(arm), .stop(stop), .mode(mode), .trig_pc(trig_pc),
        .pc_ex(pc_ex), .regwrite_ex(regwrite_ex), .regsel_ex(regsel_ex), .writedata(writedata),
        .gpio_we_wb(gpio_we_wb), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .busy(busy), .triggered(triggered), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef logic [BASE_W-1:0] rec_t;
    rec_t m_q[$];
    int   m_phase, m_mode, m_post;   // phase: 0 idle, 1 capturing, 2 post-trigger, 3 readout
    bit   m_ovf, m_trig;
    int   checks = 0, failures = 0;

    task automatic model_reset();
        m_q.delete(); m_phase = 0; m_mode = 0; m_post = 0; m_ovf = 0; m_trig = 0;
    endtask

    task automatic model_arm();
        m_q.delete(); m_ovf = 0; m_trig = 0; m_mode = (mode == 2'd3) ? 0 : int'(mode);
    endtask

    // Drive one cycle of inputs, advance the model, and step past the clock edge.
    task automatic tick(input bit a, input bit s, input bit rw, input bit gw,
                        input logic [31:0] p, input logic [31:0] d, input logic [4:0] r, input bit rr);
        int nxt;
        arm = a; stop = s; regwrite_ex = rw; gpio_we_wb = gw; pc_ex = p; writedata = d;
        regsel_ex = r; rd_ready = rr;
        nxt = m_phase;
        case (m_phase)
            0: if (a) begin model_arm(); nxt = 1; end
            1, 2: begin
                if (rw || gw) begin
                    m_q.push_back({gw, rw, r, p, d});
                    if (m_q.size() > DEPTH) begin void'(m_q.pop_front()); m_ovf = 1; end
                    if (m_phase == 1 && m_mode == 1 && m_q.size() == DEPTH) nxt = 3;
                    else if (m_phase == 1 && m_mode == 2 && p == trig_pc) begin
                        m_trig = 1; m_post = POST_TRIG; nxt = (POST_TRIG == 0) ? 3 : 2;
                    end else if (m_phase == 2) begin
                        m_post--; if (m_post == 0) nxt = 3;
                    end
                end
                if (s) nxt = 3;
            end
            default: begin
                if (a) begin model_arm(); nxt = 1; end
                else if (m_q.size() == 0) nxt = 0;
                else if (rr) begin void'(m_q.pop_front()); if (m_q.size() == 0) nxt = 0; end
            end
        endcase
        m_phase = nxt;
        @(posedge clk); #1;
        arm = 0; stop = 0; regwrite_ex = 0; gpio_we_wb = 0; rd_ready = 0;
    endtask

    task automatic do_reset();
        arm = 0; stop = 0; regwrite_ex = 0; gpio_we_wb = 0; rd_ready = 0;
        rst = 1; @(posedge clk); @(posedge clk); #1; rst = 0; model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 7'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if ({rd_valid, busy, triggered, overflow} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {rd_valid, busy, triggered, overflow}); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    endtask

    task automatic test_mode1_full();
        do_reset(); mode = 2'd1; tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70; i++) tick(0, 0, 1, 0, 32'(i * 4), $urandom, 5'($urandom), 0);
        checks++; if (count !== 7'd64) begin failures++; $display("FAIL m1_count got=%0d exp=64", count); end
        checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL m1_flags got ovf=%b busy=%b exp 0 0", overflow, busy); end
        for (int i = 0; i < 64; i++) begin
            checks++; if (rd_valid !== 1'b1 || rd_data[63:32] !== 32'(i * 4) || rd_data[BASE_W-1:0] !== m_q[0])
                begin failures++; $display("FAIL m1_drain[%0d] got=%0h exp=%0h", i, rd_data, m_q[0]); end
            tick(0, 0, 0, 0, 0, 0, 0, 1);
        end
        checks++; if (rd_valid !== 1'b0 || count !== 7'd0) begin failures++; $display("FAIL m1_empty got valid=%b count=%0d exp 0 0", rd_valid, count); end
    endtask

    task automatic test_mode0_wrap();
        do_reset(); mode = 2'd0; tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) tick(0, 0, 1, 0, $urandom, 32'(i), 5'($urandom), 0);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (count !== 7'd64 || overflow !== 1'b1) begin failures++; $display("FAIL m0_state got count=%0d ovf=%b exp 64 1", count, overflow); end
        for (int i = 0; i < 64; i++) begin
            checks++; if (rd_data[31:0] !== 32'(i + 36) || rd_data[BASE_W-1:0] !== m_q[0])
                begin failures++; $display("FAIL m0_drain[%0d] got=%0h exp=%0h", i, rd_data[31:0], i + 36); end
            tick(0, 0, 0, 0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_mode2_trigger();
        int n;
        do_reset(); mode = 2'd2; trig_pc = 32'h40; tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 16; i++) tick(0, 0, $urandom_range(0, 1) == 1, 1, 32'(i * 4), $urandom, 5'($urandom), 0);
        checks++; if (triggered !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL m2_trig got trig=%b busy=%b exp 1 1", triggered, busy); end
        for (int i = 17; i <= 32; i++) tick(0, 0, 1, 0, 32'(i * 4), $urandom, 5'($urandom), 0);
        checks++; if (busy !== 1'b0 || count !== 7'd33) begin failures++; $display("FAIL m2_done got busy=%b count=%0d exp 0 33", busy, count); end
        n = 33;
        for (int i = 0; i < n; i++) begin
            checks++; if (rd_data[63:32] !== 32'(i * 4) || rd_data[BASE_W-1:0] !== m_q[0])
                begin failures++; $display("FAIL m2_drain[%0d] got pc=%0h exp=%0h", i, rd_data[63:32], i * 4); end
            tick(0, 0, 0, 0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_ready_toggle();
        logic [REC_W-1:0] prev;
        logic [6:0]       prev_cnt;
        do_reset(); mode = 2'd0; tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            tick(0, 0, (i < 6) || ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1, $urandom, $urandom, 5'($urandom), 0);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            prev = rd_data; prev_cnt = count;
            tick(0, 0, 0, 0, 0, 0, 0, (i % 2) == 0);
            if ((i % 2) == 0) begin
                checks++; if (count !== prev_cnt - 7'd1) begin failures++; $display("FAIL rt_pop[%0d] got=%0d exp=%0d", i, count, prev_cnt - 7'd1); end
            end else begin
                checks++; if (rd_data !== prev || count !== prev_cnt) begin failures++; $display("FAIL rt_hold[%0d] got=%0h exp=%0h", i, rd_data, prev); end
            end
            checks++; if (rd_data[BASE_W-1:0] !== m_q[0]) begin failures++; $display("FAIL rt_data[%0d] got=%0h exp=%0h", i, rd_data, m_q[0]); end
        end
        tick(1, 0, 0, 0, 0, 0, 0, 1);
        checks++; if (count !== 7'd0 || busy !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL rt_rearm got count=%0d busy=%b exp 0 1", count, busy); end
    endtask

    task automatic test_simultaneous();
        do_reset(); mode = 2'd1; tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 63; i++) tick(0, 0, 1, 0, 32'(i), $urandom, 0, 0);
        tick(0, 1, 1, 0, 32'd63, 32'hABCD, 0, 0);
        checks++; if (count !== 7'd64 || busy !== 1'b0) begin failures++; $display("FAIL sim_full_stop got count=%0d busy=%b exp 64 0", count, busy); end
        do_reset(); mode = 2'd2; trig_pc = 32'h40; tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) tick(0, 0, 1, 0, 32'(i * 4), $urandom, 0, 0);
        tick(0, 1, 1, 0, 32'h40, 32'h5, 0, 0);
        checks++; if (busy !== 1'b0 || rd_valid !== 1'b1 || count !== 7'd17) begin failures++; $display("FAIL sim_trig_stop got busy=%b valid=%b count=%0d exp 0 1 17", busy, rd_valid, count); end
        do_reset(); mode = 2'd2; tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 0, 1, 0, 32'(i * 4), $urandom, 0, 0);
        checks++; if (busy !== 1'b1 || triggered !== 1'b1) begin failures++; $display("FAIL sim_post got busy=%b trig=%b exp 1 1", busy, triggered); end
        rst = 1; #1;
        checks++; if ({busy, triggered, overflow, rd_valid} !== 4'b0 || count !== 7'd0 || rd_data !== '0)
            begin failures++; $display("FAIL sim_async_rst got flags=%b count=%0d exp 0", {busy, triggered, overflow, rd_valid}, count); end
        @(posedge clk); #1; rst = 0; model_reset();
    endtask

    task automatic test_random();
        do_reset(); trig_pc = 32'h20;
        for (int c = 0; c < 1500; c++) begin
            mode = 2'($urandom);
            checks++; if (count !== 7'(m_q.size())) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", c, count, m_q.size()); end
            checks++; if (busy !== (m_phase == 1 || m_phase == 2) || triggered !== m_trig || overflow !== m_ovf)
                begin failures++; $display("FAIL rnd_flags[%0d] got=%b%b%b exp=%b%b%b", c, busy, triggered, overflow, m_phase == 1 || m_phase == 2, m_trig, m_ovf); end
            checks++; if (rd_valid !== (m_phase == 3 && m_q.size() != 0)) begin failures++; $display("FAIL rnd_valid[%0d] got=%b", c, rd_valid); end
            if (m_phase == 3 && m_q.size() != 0) begin
                checks++; if (rd_data[BASE_W-1:0] !== m_q[0]) begin failures++; $display("FAIL rnd_data[%0d] got=%0h exp=%0h", c, rd_data, m_q[0]); end
            end
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, 32'($urandom_range(0, 15) * 4), $urandom, 5'($urandom),
                 $urandom_range(0, 2) != 0);
        end
    endtask

`ifdef TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [31:0] t0;
        do_reset(); mode = 2'd0; tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 32'h10, 32'h1, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 32'h14, 32'h2, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        t0 = rd_data[REC_W-1 -: 32];
        tick(0, 0, 0, 0, 0, 0, 0, 1);
        checks++; if (rd_data[REC_W-1 -: 32] - t0 !== 32'd3) begin failures++; $display("FAIL ts_delta got=%0d exp=3", rd_data[REC_W-1 -: 32] - t0); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_mode1_full();
        test_mode0_wrap();
        test_mode2_trigger();
        test_ready_toggle();
        test_simultaneous();
        test_random();
`ifdef TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
